// File: rtl/spi_cmd_ram.sv
// -----------------------------------------------------------------------------
// spi_cmd_ram
//   Command-driven single-port RAM that sits behind an SPI slave front-end.
//   Each accepted word carries an opcode in din[WORD_SIZE+1:WORD_SIZE] and a
//   payload in din[WORD_SIZE-1:0]:
//     00 load write address   01 write data at write address
//     10 load read address    11 read data at read address -> dout, tx_valid
//
// Ports
//   clk       in   rising-edge clock for all logic
//   rst_n     in   synchronous reset, active HIGH (asserted = 1); the name is
//                  kept for compatibility with the surrounding codebase
//   din       in   [WORD_SIZE+1:WORD_SIZE] opcode, [WORD_SIZE-1:0] payload
//   rx_valid  in   din is valid this cycle; din is ignored when low
//   dout      out  read data, holds its last value between reads
//   tx_valid  out  one-cycle strobe per accepted read command
//
// MEM_DEPTH must equal 2**ADDR_SIZE and ADDR_SIZE must not exceed WORD_SIZE:
// addresses are taken from the low bits of the payload and never wrap.
// -----------------------------------------------------------------------------

// Storage array. Kept as its own module so test benches and memory-compiler
// swaps can reach it at U1_spr.mem.
module spi_cmd_ram_spr #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8,
  parameter int WORD_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_SIZE-1:0] wr_addr,
  input  logic [WORD_SIZE-1:0] wr_data,
  input  logic [ADDR_SIZE-1:0] rd_addr,
  output logic [WORD_SIZE-1:0] rd_data
);

  logic [WORD_SIZE-1:0] mem [0:MEM_DEPTH-1];

  // NOTE: the array has no reset on purpose: preloaded contents must survive
  // a reset, and a resettable array cannot map onto a RAM macro.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Asynchronous read; the registered output lives in the parent.
  assign rd_data = mem[rd_addr];

endmodule

module spi_cmd_ram #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8,
  parameter int WORD_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WORD_SIZE+1:0] din,
  input  logic                 rx_valid,
  output logic [WORD_SIZE-1:0] dout,
  output logic                 tx_valid
);

  typedef enum logic [1:0] {
    OP_WR_ADDR = 2'b00,
    OP_WR_DATA = 2'b01,
    OP_RD_ADDR = 2'b10,
    OP_RD_DATA = 2'b11
  } op_e;

  op_e                  op;
  logic [WORD_SIZE-1:0] payload;
  logic [ADDR_SIZE-1:0] wr_addr;
  logic [ADDR_SIZE-1:0] rd_addr;
  logic [WORD_SIZE-1:0] mem_rd_data;
  logic                 mem_we;
  logic                 accept;

  assign op      = op_e'(din[WORD_SIZE+1:WORD_SIZE]);
  assign payload = din[WORD_SIZE-1:0];

  // A command is only taken out of reset; reset wins over any command.
  assign accept = !rst_n && rx_valid;
  assign mem_we = accept && (op == OP_WR_DATA);

  spi_cmd_ram_spr #(
    .MEM_DEPTH (MEM_DEPTH),
    .ADDR_SIZE (ADDR_SIZE),
    .WORD_SIZE (WORD_SIZE)
  ) U1_spr (
    .clk     (clk),
    .we      (mem_we),
    .wr_addr (wr_addr),
    .wr_data (payload),
    .rd_addr (rd_addr),
    .rd_data (mem_rd_data)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of the others (e.g. a write uses the old
  // wr_addr even if a later cycle reloads it).
  always_ff @(posedge clk) begin
    if (rst_n) begin
      wr_addr  <= '0;
      rd_addr  <= '0;
      dout     <= '0;
      tx_valid <= 1'b0;
    end else begin
      // Strobe defaults low; only an accepted read raises it for one cycle.
      tx_valid <= 1'b0;
      if (rx_valid) begin
        unique case (op)
          OP_WR_ADDR: wr_addr <= payload[ADDR_SIZE-1:0];
          OP_WR_DATA: ; // memory write handled by mem_we
          OP_RD_ADDR: rd_addr <= payload[ADDR_SIZE-1:0];
          OP_RD_DATA: begin
            dout     <= mem_rd_data;
            tx_valid <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_cmd_ram.sv
// -----------------------------------------------------------------------------
// tb_spi_cmd_ram
//   Self-checking bench for spi_cmd_ram. A behavioural model (an array plus
//   the two address registers and the expected outputs) is advanced once per
//   clock from the command rules and compared against dout/tx_valid after
//   every edge. Directed scenarios are followed by a randomized phase.
// -----------------------------------------------------------------------------
module tb_spi_cmd_ram;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] din;
  logic       rx_valid;
  logic [7:0] dout;
  logic       tx_valid;

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  logic [7:0] ref_mem [0:255];
  logic [7:0] ref_wr_addr;
  logic [7:0] ref_rd_addr;
  logic [7:0] ref_dout;
  logic       ref_tx;

  spi_cmd_ram dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .din      (din),
    .rx_valid (rx_valid),
    .dout     (dout),
    .tx_valid (tx_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] observed,
                       input logic [7:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%02h expected 0x%02h (t=%0t)",
               tag, observed, expected, $time);
    end
  endtask

  // Apply one cycle of stimulus, advance the model, then compare outputs.
  task automatic step(input string tag, input logic rst, input logic rx,
                      input logic [9:0] d);
    rst_n    = rst;
    rx_valid = rx;
    din      = d;
    @(posedge clk);
    if (rst) begin
      ref_wr_addr = 8'h00;
      ref_rd_addr = 8'h00;
      ref_dout    = 8'h00;
      ref_tx      = 1'b0;
    end else begin
      ref_tx = 1'b0;
      if (rx) begin
        case (d[9:8])
          2'b00: ref_wr_addr = d[7:0];
          2'b01: ref_mem[ref_wr_addr] = d[7:0];
          2'b10: ref_rd_addr = d[7:0];
          default: begin
            ref_dout = ref_mem[ref_rd_addr];
            ref_tx   = 1'b1;
          end
        endcase
      end
    end
    #1;
    check({tag, ".dout"}, dout, ref_dout);
    check({tag, ".tx_valid"}, {7'b0, tx_valid}, {7'b0, ref_tx});
  endtask

  initial begin
    logic [7:0] pre_ff;
    logic [7:0] pre_03;

    rst_n    = 1'b1;
    rx_valid = 1'b0;
    din      = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 'x;

    // Bring the block to a known state, then preload every word through the
    // command port with random data.
    step("init_rst", 1'b1, 1'b0, 10'h000);
    for (int a = 0; a < 256; a++) begin
      step("pre_addr", 1'b0, 1'b1, {2'b00, 8'(a)});
      step("pre_data", 1'b0, 1'b1, {2'b01, 8'($urandom_range(255))});
    end
    pre_ff = ref_mem[8'hFF];
    pre_03 = ref_mem[8'h03];

    // Reset for 5 cycles: outputs cleared.
    for (int i = 0; i < 5; i++) step("reset", 1'b1, 1'b0, 10'h000);
    // Memory survives reset: read 0xFF back against its preload value.
    step("rd_ff_addr", 1'b0, 1'b1, 10'h2FF);
    step("rd_ff_pre", 1'b0, 1'b1, 10'h300);
    check("mem_ff_kept", dout, pre_ff);

    // Write 0x03 to 0xFF.
    step("wr_addr", 1'b0, 1'b1, 10'h0FF);
    step("wr_data", 1'b0, 1'b1, 10'h103);

    // Gated input: neither command may take effect.
    step("gated_addr", 1'b0, 1'b0, 10'h0FE);
    step("gated_data", 1'b0, 1'b0, 10'h107);

    // Read 0xFF, held for 5 cycles.
    step("rd_addr", 1'b0, 1'b1, 10'h2FF);
    for (int i = 0; i < 5; i++) begin
      step("rd_hold", 1'b0, 1'b1, 10'h3F3);
      check("rd_hold_val", dout, 8'h03);
      check("rd_hold_tx", {7'b0, tx_valid}, 8'h01);
    end
    step("idle", 1'b0, 1'b0, 10'h3F3);
    check("idle_tx", {7'b0, tx_valid}, 8'h00);

    // 0xFE untouched by the gated write.
    step("rd_fe_addr", 1'b0, 1'b1, 10'h2FE);
    step("rd_fe", 1'b0, 1'b1, 10'h300);

    // Read-address switch.
    step("sw_fe", 1'b0, 1'b1, 10'h2FE);
    step("sw_03", 1'b0, 1'b1, 10'h203);
    check("sw_tx_low", {7'b0, tx_valid}, 8'h00);
    step("sw_rd", 1'b0, 1'b1, 10'h303);
    check("sw_rd_val", dout, pre_03);

    // Reset coincident with a read command: reset wins.
    step("rst_mid_rd", 1'b1, 1'b1, 10'h303);
    check("rst_mid_dout", dout, 8'h00);
    step("post_rst_addr", 1'b0, 1'b1, 10'h203);
    step("post_rst_rd", 1'b0, 1'b1, 10'h303);
    check("mem_03_kept", dout, pre_03);

    // Randomized phase with occasional resets.
    for (int i = 0; i < 2000; i++) begin
      step("rand", ($urandom_range(31) == 0), ($urandom_range(3) != 0),
           10'($urandom_range(1023)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_cmd_ram.md
Name: spi_cmd_ram

Overview:
- Command-driven single-port RAM (default 256 x 8) sitting behind an SPI slave front-end.
- Each accepted 10-bit word carries a 2-bit opcode in din[9:8] and an 8-bit payload in din[7:0]. The opcode selects one of: load write address, write data, load read address, read data.
- Read data returns on dout with a tx_valid strobe; the SPI slave serialises it back to the master.

Parameters:
- MEM_DEPTH, 256, number of memory words.
- ADDR_SIZE, 8, address width; MEM_DEPTH must equal 2**ADDR_SIZE.
- WORD_SIZE, 8, data width; din is WORD_SIZE+2 bits.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  synchronous reset, active-high (port keeps the codebase name; asserted = 1).
- din  in  10  [9:8] opcode, [7:0] address or data payload.
- rx_valid  in  1  din valid this cycle; din is ignored when 0.
- dout  out  8  read data.
- tx_valid  out  1  dout valid strobe.

Behaviour:
- Reset (rst_n=1 at a rising edge):
  - dout=0, tx_valid=0, internal wr_addr=0, rd_addr=0.
  - Memory contents are NOT cleared, so preloaded data survives.
  - Reset has priority over any command in the same cycle.
- Storage:
  - Held in a sub-instance named U1_spr, whose array is named mem [0:MEM_DEPTH-1].
  - Benches may backdoor-preload it with $readmemh on that hierarchical path.
- Command decode: evaluated only when rst_n=0 and rx_valid=1, on the rising edge.
  - 00: wr_addr <= din[7:0]; tx_valid <= 0; dout holds.
  - 01: mem[wr_addr] <= din[7:0]; uses wr_addr as registered before this edge; wr_addr unchanged; tx_valid <= 0.
  - 10: rd_addr <= din[7:0]; tx_valid <= 0; dout holds.
  - 11: dout <= mem[rd_addr]; tx_valid <= 1; din[7:0] is don't-care.
- rx_valid=0: no state change except tx_valid <= 0; dout holds its last value.
- Latency and strobe:
  - Read data appears one clock after the 11 command edge.
  - tx_valid is high for exactly the cycles following each accepted 11 command.
  - 11 held with rx_valid=1 for N cycles gives tx_valid high N cycles, re-reading mem[rd_addr] each cycle.
- Addresses: no auto-increment; addresses stay constant until reloaded and never wrap.
- Hazards:
  - 01 then 11 to the same address in later cycles returns the new data.
  - Only one command per cycle, so a simultaneous read and write cannot occur.
- No X propagation on dout after reset; the memory is uninitialised unless preloaded.

Test Plan:
1. Reset.
   - Stimulus: preload mem from file, drive rst_n=1 for 5 cycles with din=0, rx_valid=0.
   - Response: dout=0x00, tx_valid=0; mem[0xFF] still equals its preload value.
2. Write.
   - Stimulus: rst_n=0, rx_valid=1, din=0x0FF, then din=0x103.
   - Response: mem[0xFF]=0x03; tx_valid stays 0.
3. Gated input.
   - Stimulus: rx_valid=0, din=0x0FE, then 0x107.
   - Response: wr_addr still 0xFF; mem[0xFE] and mem[0xFF] unchanged.
4. Read.
   - Stimulus: rx_valid=1, din=0x2FF, then 0x3F3 held 5 cycles.
   - Response: from the cycle after the first 0x3F3 edge, dout=0x03 and tx_valid=1 for 5 cycles.
5. Read-address switch.
   - Stimulus: din=0x2FE, then 0x203, then 0x303.
   - Response: dout=preload mem[0x03], tx_valid=1 one cycle after the 0x303 edge; tx_valid=0 after the 0x2xx commands.
6. Reset mid-read.
   - Stimulus: assert rst_n=1 in the same cycle as din=0x303, rx_valid=1.
   - Response: next cycle dout=0, tx_valid=0; mem[0x03] is not cleared.
